lvds_decoder: RTL and testbench
===============================

# lvds_decoder

Receive-side counterpart of the team's LVDS pixel encoder. It takes 5-bit parallel words from four 1:5 input deserializers (one clock lane, three data lanes), all delivered at pclkx2. It word-aligns the deserializers by pulsing a shared bitslip, using the clock-lane pattern as the reference. It then reassembles each pair of 15-bit half-words into one 30-bit {red, green, blue} pixel with a valid strobe.

## Interface
- SETTLE, default 4: cycles to wait after a bitslip pulse before checking words again (range 1-15).
- LOCK_COUNT, default 16: consecutive good clock words required to declare lock (range 2-255).
- ERR_LIMIT, default 4: consecutive bad clock words in LOCKED that cause lock loss (range 1-15).
- pclkx2  in  1  pixel clock ×2; all logic is on its rising edge.
- serdes_rst  in  1  reset, asynchronous, active-high.
- rx_c  in  5  clock-lane deserialized word.
- rx_0  in  5  lane 0 (blue) word.
- rx_1  in  5  lane 1 (green) word.
- rx_2  in  5  lane 2 (red) word.
- bitslip  out  1  one-cycle pulse, fanned out to all four deserializers.
- locked  out  1  high while in the LOCKED state.
- d  out  30  pixel {red[9:0], green[9:0], blue[9:0]}.
- d_valid  out  1  d is a new pixel this cycle.
- loss_cnt  out  8  count of LOCKED→SLIP transitions; saturates at 255.

## Operation
- Clock-word classes:
  - HI = 5'b11111.
  - LO = 5'b00000.
  - anything else is BAD.
- A word is good when it is HI or LO and differs in class from the previous word. HI after HI is an error, as is LO after LO. The first word checked after entering CHECK needs only to be HI or LO.
- Half-word meaning:
  - A HI cycle carries the upper half: rx_2 = red[9:5], rx_1 = green[9:5], rx_0 = blue[9:5].
  - The following LO cycle carries the lower half, mapped the same way onto bits [4:0].
- FSM states: CHECK, SLIP, WAIT, LOCKED. Reset state is CHECK.
- CHECK:
  - Each good word increments good_cnt.
  - When good_cnt reaches LOCK_COUNT, go to LOCKED.
  - Any bad word clears good_cnt and goes to SLIP.
- SLIP:
  - Drive bitslip high for exactly one cycle, then go to WAIT.
  - slip_idx advances 0→4 and wraps to 0; it is a status counter only.
- WAIT: hold for SETTLE cycles, ignoring all words, then go to CHECK with good_cnt = 0.
- LOCKED:
  - On a HI word, latch the upper halves into hold registers.
  - On a good LO word whose preceding word was a good HI, emit a pixel.
  - A bad word increments err_run and suppresses the pixel pair it belongs to.
  - A good word clears err_run.
  - When err_run reaches ERR_LIMIT, go to SLIP and increment loss_cnt (saturating at 255).
- A pixel is emitted only if both of its halves were good words.
- Data lanes are never checked; only the clock lane drives alignment.

## Timing
- Reset values: bitslip = 0, locked = 0, d = 0, d_valid = 0, loss_cnt = 0. Internal counters and hold registers are 0, and the state is CHECK.
- Assertion of serdes_rst clears everything immediately, including a bitslip pulse already in progress. Release takes effect synchronously at the next pclkx2 edge.
- Latency: for a LO word sampled at edge n, d and d_valid are registered at edge n and held stable for the following cycle.
  - d_valid is a one-cycle pulse.
  - Maximum rate is one pixel every 2 cycles.
  - d holds its last value while d_valid is low.
- locked:
  - Rises on the edge where good_cnt reaches LOCK_COUNT.
  - d_valid cannot be asserted before one full HI→LO pair has been received after lock.
  - Falls on the edge that enters SLIP.
- Minimum spacing between bitslip pulses is SETTLE + 2 cycles.
- If LOCKED sees a bad word on the ERR_LIMIT-th error, the SLIP transition wins and no pixel is emitted.

## Structure
- Shared package lvds_pkg holds:
  - the clock-word constants CLK_HI and CLK_LO;
  - the state enum {CHECK, SLIP, WAIT, LOCKED};
  - lane index constants (RED=2, GRN=1, BLU=0), shared with the encoder.
- Sub-module lvds_gearbox_15to30 holds the upper-half register and assembles the 30-bit pixel. Its inputs are the word strobe, the HI/LO class, the good flag and the three lanes. Its outputs are d and d_valid.
- The alignment FSM and all counters live in lvds_decoder.

## Test plan
1. Aligned stream, defaults:
   - Stimulus: rx_c alternates HI/LO from reset release, with the data pattern R=0x2A5, G=0x15A, B=0x3C3.
   - Required: locked rises after 16 good words, no bitslip pulses, and d = {0x2A5, 0x15A, 0x3C3} with d_valid on every LO cycle thereafter.
2. Misalignment by 3 bits:
   - Stimulus: the model emits rotated words (e.g. 11100/00011) and un-rotates by one bit per bitslip.
   - Required: exactly 3 bitslip pulses, each at least SETTLE + 2 cycles apart, then locked after 16 good words.
3. Bad words in LOCKED:
   - Stimulus: 3 bad clock words, then good words.
   - Required: locked stays 1, the affected pixels are dropped (no d_valid), and loss_cnt stays 0.
   - Stimulus: then 4 consecutive bad words.
   - Required: bitslip pulses, locked drops, and loss_cnt = 1.
4. Repeated-class error: HI, HI in LOCKED → the second HI counts as an error and no pixel is produced for that pair.
5. Reset mid-slip: assert serdes_rst during the bitslip-high cycle → bitslip drops immediately and all outputs read 0 until relock.
6. Saturation: force 300 lock losses → loss_cnt holds at 255.

Source files
------------

// File: rtl/lvds_pkg.sv
// Shared constants and types for the LVDS pixel link (encoder and decoder).
package lvds_pkg;

    localparam logic [4:0] CLK_HI = 5'b11111;
    localparam logic [4:0] CLK_LO = 5'b00000;

    localparam int RED = 2;
    localparam int GRN = 1;
    localparam int BLU = 0;

    typedef enum logic [1:0] {
        CHECK,
        SLIP,
        WAIT,
        LOCKED
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_HI,
        CLS_LO
    } cls_t;

endpackage

// File: rtl/lvds_gearbox_15to30.sv
// Pairs an upper (HI) and lower (LO) 15-bit half-word into one 30-bit pixel.
module lvds_gearbox_15to30
    import lvds_pkg::*;
(
    input  logic            pclkx2,
    input  logic            serdes_rst,
    input  logic            strobe,
    input  logic            hi,
    input  logic            good,
    input  logic [2:0][4:0] lanes,
    output logic [29:0]     d,
    output logic            d_valid
);

    logic [2:0][4:0] upper;
    logic            hi_ok;

    // hi_ok remembers whether the previous strobed word was a good HI
    always_ff @(posedge pclkx2 or posedge serdes_rst) begin
        if (serdes_rst) begin
            upper   <= '0;
            hi_ok   <= 1'b0;
            d       <= '0;
            d_valid <= 1'b0;
        end else begin
            d_valid <= 1'b0;
            if (strobe) begin
                hi_ok <= hi && good;
                if (hi) begin
                    upper <= lanes;
                end else if (good && hi_ok) begin
                    d <= {upper[RED], lanes[RED],
                          upper[GRN], lanes[GRN],
                          upper[BLU], lanes[BLU]};
                    d_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lvds_decoder.sv
// LVDS receive decoder: clock-lane word alignment via bitslip, then pixel assembly.
module lvds_decoder
    import lvds_pkg::*;
#(
    parameter int SETTLE     = 4,
    parameter int LOCK_COUNT = 16,
    parameter int ERR_LIMIT  = 4
) (
    input  logic        pclkx2,
    input  logic        serdes_rst,
    input  logic [4:0]  rx_c,
    input  logic [4:0]  rx_0,
    input  logic [4:0]  rx_1,
    input  logic [4:0]  rx_2,
    output logic        bitslip,
    output logic        locked,
    output logic [29:0] d,
    output logic        d_valid,
    output logic [7:0]  loss_cnt
);

    localparam logic [7:0] LOCK_N   = 8'(LOCK_COUNT);
    localparam logic [3:0] ERR_N    = 4'(ERR_LIMIT);
    localparam logic [3:0] SETTLE_L = 4'(SETTLE - 1);

    state_t     state, state_n;
    cls_t       cls, prev_cls, prev_n;
    logic [7:0] good_cnt, good_n;
    logic [3:0] err_run, err_n;
    logic [3:0] wait_cnt, wait_n;
    logic [2:0] slip_idx, slip_n;
    logic [7:0] loss_n;
    logic       good;

    assign cls = (rx_c == CLK_HI) ? CLS_HI :
                 (rx_c == CLK_LO) ? CLS_LO : CLS_NONE;
    // prev_cls is CLS_NONE after a bad word or on entry to CHECK
    assign good = (cls != CLS_NONE) && (cls != prev_cls);

    always_ff @(posedge pclkx2 or posedge serdes_rst) begin
        if (serdes_rst) begin
            state    <= CHECK;
            prev_cls <= CLS_NONE;
            good_cnt <= '0;
            err_run  <= '0;
            wait_cnt <= '0;
            slip_idx <= '0;
            loss_cnt <= '0;
        end else begin
            state    <= state_n;
            prev_cls <= prev_n;
            good_cnt <= good_n;
            err_run  <= err_n;
            wait_cnt <= wait_n;
            slip_idx <= slip_n;
            loss_cnt <= loss_n;
        end
    end

    always_comb begin
        state_n = state;
        prev_n  = prev_cls;
        good_n  = good_cnt;
        err_n   = err_run;
        wait_n  = wait_cnt;
        slip_n  = slip_idx;
        loss_n  = loss_cnt;
        unique case (state)
            CHECK: begin
                prev_n = cls;
                if (good) begin
                    good_n = good_cnt + 8'd1;
                    if (good_n == LOCK_N) begin
                        state_n = LOCKED;
                        err_n   = '0;
                    end
                end else begin
                    good_n  = '0;
                    prev_n  = CLS_NONE;
                    state_n = SLIP;
                end
            end
            SLIP: begin
                slip_n  = (slip_idx == 3'd4) ? 3'd0 : slip_idx + 3'd1;
                wait_n  = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (wait_cnt == SETTLE_L) begin
                    state_n = CHECK;
                    good_n  = '0;
                end else begin
                    wait_n = wait_cnt + 4'd1;
                end
            end
            LOCKED: begin
                prev_n = cls;
                if (good) begin
                    err_n = '0;
                end else begin
                    err_n = err_run + 4'd1;
                    if (err_n == ERR_N) begin
                        state_n = SLIP;
                        prev_n  = CLS_NONE;
                        if (loss_cnt != 8'hFF)
                            loss_n = loss_cnt + 8'd1;
                    end
                end
            end
        endcase
    end

    assign bitslip = (state == SLIP);
    assign locked  = (state == LOCKED);

    logic [2:0][4:0] lanes;
    assign lanes[RED] = rx_2;
    assign lanes[GRN] = rx_1;
    assign lanes[BLU] = rx_0;

    lvds_gearbox_15to30 u_gearbox (
        .pclkx2     (pclkx2),
        .serdes_rst (serdes_rst),
        .strobe     (state == LOCKED),
        .hi         (cls == CLS_HI),
        .good       (good),
        .lanes      (lanes),
        .d          (d),
        .d_valid    (d_valid)
    );

endmodule

// File: tb/tb_lvds_decoder.sv
// Directed, table-driven bench for lvds_decoder.
`timescale 1ns/1ps
module tb_lvds_decoder;

    localparam int SETTLE     = 4;
    localparam int LOCK_COUNT = 16;
    localparam int ERR_LIMIT  = 4;

    localparam logic [4:0] HI  = 5'b11111;
    localparam logic [4:0] LO  = 5'b00000;
    localparam logic [4:0] BAD = 5'b10101;

    localparam logic [29:0] P1 = {10'h2A5, 10'h15A, 10'h3C3};
    localparam logic [29:0] P2 = {10'h3FF, 10'h000, 10'h155};
    localparam logic [29:0] P3 = {10'h001, 10'h200, 10'h0AA};

    logic        pclkx2 = 1'b0;
    logic        serdes_rst = 1'b1;
    logic [4:0]  rx_c = '0;
    logic [4:0]  rx_0 = '0;
    logic [4:0]  rx_1 = '0;
    logic [4:0]  rx_2 = '0;
    logic        bitslip;
    logic        locked;
    logic [29:0] d;
    logic        d_valid;
    logic [7:0]  loss_cnt;

    int checks = 0;
    int errors = 0;

    always #5 pclkx2 = ~pclkx2;

    lvds_decoder #(
        .SETTLE     (SETTLE),
        .LOCK_COUNT (LOCK_COUNT),
        .ERR_LIMIT  (ERR_LIMIT)
    ) dut (
        .pclkx2     (pclkx2),
        .serdes_rst (serdes_rst),
        .rx_c       (rx_c),
        .rx_0       (rx_0),
        .rx_1       (rx_1),
        .rx_2       (rx_2),
        .bitslip    (bitslip),
        .locked     (locked),
        .d          (d),
        .d_valid    (d_valid),
        .loss_cnt   (loss_cnt)
    );

    typedef struct {
        logic [4:0]  c;
        logic [29:0] pix;
        logic        hi;
        logic        ev;
        logic [29:0] ed;
        logic        el;
        logic        eb;
        logic [7:0]  eloss;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic [4:0] c, input logic [29:0] pix,
                                input logic hi, input logic ev,
                                input logic [29:0] ed, input logic el,
                                input logic eb, input logic [7:0] eloss);
        vec_t v;
        v.c = c; v.pix = pix; v.hi = hi; v.ev = ev;
        v.ed = ed; v.el = el; v.eb = eb; v.eloss = eloss;
        return v;
    endfunction

    function automatic logic [4:0] rot(input int t, input int off);
        logic [4:0] w;
        for (int j = 0; j < 5; j++)
            w[4-j] = ((((5 * t + off + j) / 5) % 2) == 0);
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclkx2);
        #1;
    endtask

    task automatic drive(input logic [4:0] c, input logic [29:0] pix,
                         input logic hi);
        rx_c = c;
        rx_2 = hi ? pix[29:25] : pix[24:20];
        rx_1 = hi ? pix[19:15] : pix[14:10];
        rx_0 = hi ? pix[9:5]   : pix[4:0];
    endtask

    task automatic do_reset();
        serdes_rst = 1'b1;
        drive(LO, '0, 1'b0);
        repeat (2) tick();
        serdes_rst = 1'b0;
    endtask

    initial begin
        int nbs;
        int nbad;
        int off;
        int nslip;
        int last;
        int minsp;
        int lockt;
        int nlock;
        int nslp;
        int exp_loss;
        bit found;

        vecs[0]  = mk(HI,  P1, 1, 0, '0, 1, 0, 0);
        vecs[1]  = mk(LO,  P1, 0, 1, P1, 1, 0, 0);
        vecs[2]  = mk(HI,  P2, 1, 0, P1, 1, 0, 0);
        vecs[3]  = mk(LO,  P2, 0, 1, P2, 1, 0, 0);
        vecs[4]  = mk(BAD, P3, 1, 0, P2, 1, 0, 0);
        vecs[5]  = mk(BAD, P3, 0, 0, P2, 1, 0, 0);
        vecs[6]  = mk(BAD, P3, 1, 0, P2, 1, 0, 0);
        vecs[7]  = mk(HI,  P3, 1, 0, P2, 1, 0, 0);
        vecs[8]  = mk(LO,  P3, 0, 1, P3, 1, 0, 0);
        vecs[9]  = mk(HI,  P1, 1, 0, P3, 1, 0, 0);
        vecs[10] = mk(HI,  P1, 1, 0, P3, 1, 0, 0);
        vecs[11] = mk(LO,  P1, 0, 0, P3, 1, 0, 0);
        vecs[12] = mk(HI,  P2, 1, 0, P3, 1, 0, 0);
        vecs[13] = mk(LO,  P2, 0, 1, P2, 1, 0, 0);
        vecs[14] = mk(HI,  P1, 1, 0, P2, 1, 0, 0);
        vecs[15] = mk(5'b00100, P1, 0, 0, P2, 1, 0, 0);
        vecs[16] = mk(HI,  P1, 1, 0, P2, 1, 0, 0);
        vecs[17] = mk(LO,  P1, 0, 1, P1, 1, 0, 0);
        vecs[18] = mk(BAD, P2, 1, 0, P1, 1, 0, 0);
        vecs[19] = mk(BAD, P2, 0, 0, P1, 1, 0, 0);
        vecs[20] = mk(BAD, P2, 1, 0, P1, 1, 0, 0);
        vecs[21] = mk(BAD, P2, 0, 0, P1, 0, 1, 1);
        vecs[22] = mk(LO,  P1, 0, 0, P1, 0, 0, 1);

        // reset state
        do_reset();
        chk("rst_bitslip", bitslip, 0);
        chk("rst_locked", locked, 0);
        chk("rst_d", d, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_loss", loss_cnt, 0);

        // aligned stream: lock after LOCK_COUNT good words
        nbs = 0;
        nbad = 0;
        for (int i = 1; i <= LOCK_COUNT; i++) begin
            drive((i % 2) ? HI : LO, P1, (i % 2) == 1);
            tick();
            if (bitslip) nbs++;
            if (d_valid) nbad++;
            if (i == LOCK_COUNT - 1) chk("lock_early", locked, 0);
        end
        chk("lock_at_16", locked, 1);
        chk("aligned_no_slip", nbs, 0);
        chk("no_valid_before_lock", nbad, 0);

        // LOCKED behaviour table
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].c, vecs[i].pix, vecs[i].hi);
            tick();
            chk($sformatf("vec%0d_valid", i), d_valid, vecs[i].ev);
            chk($sformatf("vec%0d_d", i), d, vecs[i].ed);
            chk($sformatf("vec%0d_locked", i), locked, vecs[i].el);
            chk($sformatf("vec%0d_bitslip", i), bitslip, vecs[i].eb);
            chk($sformatf("vec%0d_loss", i), loss_cnt, vecs[i].eloss);
        end

        // reset during the bitslip-high cycle
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            drive(BAD, P2, 1'b0);
            tick();
            if (bitslip) found = 1;
        end
        chk("slip_before_rst", bitslip, 1);
        #2;
        serdes_rst = 1'b1;
        #1;
        chk("midslip_bitslip", bitslip, 0);
        chk("midslip_locked", locked, 0);
        chk("midslip_d", d, 0);
        chk("midslip_d_valid", d_valid, 0);
        chk("midslip_loss", loss_cnt, 0);
        tick();
        serdes_rst = 1'b0;
        nbad = 0;
        for (int i = 1; i <= LOCK_COUNT; i++) begin
            drive((i % 2) ? HI : LO, P3, (i % 2) == 1);
            tick();
            if (d_valid || d != 0 || loss_cnt != 0 || bitslip) nbad++;
            if (i < LOCK_COUNT && locked) nbad++;
        end
        chk("zero_until_relock", nbad, 0);
        chk("relock", locked, 1);

        // misaligned by 3 bits
        do_reset();
        off = 3;
        nslip = 0;
        last = -100;
        minsp = 1000;
        lockt = -1;
        for (int t = 0; t < 300; t++) begin
            rx_c = rot(t, off);
            tick();
            if (bitslip) begin
                if (nslip > 0 && t - last < minsp) minsp = t - last;
                last = t;
                nslip++;
                if (off > 0) off--;
            end
            if (locked) begin
                lockt = t;
                break;
            end
        end
        chk("misalign_slips", nslip, 3);
        chk("misalign_spacing", minsp >= SETTLE + 2, 1);
        chk("misalign_locked", locked, 1);
        chk("misalign_lock_delay", lockt - last, SETTLE + 1 + LOCK_COUNT);

        // loss counter saturation
        do_reset();
        nlock = 0;
        nslp = 0;
        for (int k = 1; k <= 300; k++) begin
            if (k > 1) begin
                repeat (5) begin
                    rx_c = LO;
                    tick();
                end
            end
            for (int i = 0; i < LOCK_COUNT; i++) begin
                rx_c = (i % 2) ? LO : HI;
                tick();
            end
            if (locked) nlock++;
            for (int i = 0; i < ERR_LIMIT; i++) begin
                rx_c = 5'b01010;
                tick();
            end
            if (bitslip && !locked) nslp++;
            exp_loss = (k > 255) ? 255 : k;
            if (k == 1 || k == 254 || k == 255 || k == 256 || k == 300)
                chk($sformatf("loss_after_%0d", k), 32'(loss_cnt), exp_loss);
        end
        chk("sat_locks", nlock, 300);
        chk("sat_slips", nslp, 300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
